// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl
//
// Button-driven saturating parameter stepper. Takes two debounced button levels
// (up, down) and maintains a bounded parameter register. A press produces one
// step; holding a button auto-repeats after a long-press delay.
//
// Parameters:
//   WIDTH         - width of value_o
//   MIN_VAL       - lower saturation bound
//   MAX_VAL       - upper saturation bound
//   INIT_VAL      - reset value (MIN_VAL <= INIT_VAL <= MAX_VAL <= 2^WIDTH-1)
//   STEP          - increment/decrement amount (>= 1)
//   HOLD_CYCLES   - held cycles after the press before auto-repeat starts (>= 2)
//   REPEAT_CYCLES - cycles between auto-repeat steps (>= 1)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   up_i      in   debounced up button level, synchronous to clk
//   down_i    in   debounced down button level, synchronous to clk
//   value_o   out  current parameter value (registered)
//   changed_o out  one-cycle pulse in the cycle value_o takes a new value
//   at_min_o  out  registered, high when value_o == MIN_VAL
//   at_max_o  out  registered, high when value_o == MAX_VAL
module btn_step_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 63,
  parameter int unsigned INIT_VAL      = 16,
  parameter int unsigned STEP          = 1,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] value_o,
  output logic             changed_o,
  output logic             at_min_o,
  output logic             at_max_o
);

  // One counter width shared by both phases of both buttons.
  localparam int unsigned CntMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  // The counter restarts at 0 on the cycle after an event, so the event fires
  // when it reaches period-1.
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);

  localparam int unsigned BtnUp = 0;
  localparam int unsigned BtnDn = 1;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } state_e;

  // ---------------------------------------------------------------------------
  // Per-button press / hold / repeat FSMs
  // ---------------------------------------------------------------------------
  logic [1:0]      level;
  logic [1:0]      prev_q;
  logic [1:0]      ev_d, ev_q;
  state_e          state_q [2];
  state_e          state_d [2];
  logic [CntW-1:0] cnt_q   [2];
  logic [CntW-1:0] cnt_d   [2];

  assign level = {down_i, up_i};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      ev_d[b]    = 1'b0;

      if (!level[b]) begin
        // Releasing from any state abandons the hold.
        state_d[b] = StIdle;
        cnt_d[b]   = '0;
      end else begin
        unique case (state_q[b])
          StIdle: begin
            // Only a low-to-high transition counts; prev_q resets high so a
            // button held across reset never fires.
            if (!prev_q[b]) begin
              ev_d[b]    = 1'b1;
              cnt_d[b]   = '0;
              state_d[b] = StHold;
            end
          end
          StHold: begin
            if (cnt_q[b] == HoldLast) begin
              ev_d[b]    = 1'b1;
              cnt_d[b]   = '0;
              state_d[b] = StRepeat;
            end else begin
              cnt_d[b] = cnt_q[b] + 1'b1;
            end
          end
          StRepeat: begin
            if (cnt_q[b] == RepLast) begin
              ev_d[b]  = 1'b1;
              cnt_d[b] = '0;
            end else begin
              cnt_d[b] = cnt_q[b] + 1'b1;
            end
          end
          default: begin
            state_d[b] = StIdle;
            cnt_d[b]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b11;
      ev_q   <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= StIdle;
        cnt_q[b]   <= '0;
      end
    end else begin
      prev_q <= level;
      ev_q   <= ev_d;
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating value register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic             at_min_q, at_min_d;
  logic             at_max_q, at_max_d;
  logic [31:0]      cur;
  logic [WIDTH-1:0] up_res, dn_res;

  assign cur = 32'(value_q);

  // value_q is always inside [MIN_VAL, MAX_VAL], so the headroom differences
  // below never wrap, and the sums are only formed when they stay in range.
  always_comb begin
    up_res = value_q;
    dn_res = value_q;
    if ((MAX_VAL - cur) < STEP) begin
      up_res = WIDTH'(MAX_VAL);
    end else begin
      up_res = WIDTH'(cur + STEP);
    end
    if ((cur - MIN_VAL) < STEP) begin
      dn_res = WIDTH'(MIN_VAL);
    end else begin
      dn_res = WIDTH'(cur - STEP);
    end
  end

  always_comb begin
    value_d = value_q;
    // Coinciding up and down events cancel out.
    unique case (ev_q)
      2'b01:   value_d = up_res;
      2'b10:   value_d = dn_res;
      default: value_d = value_q;
    endcase
    changed_d = (value_d != value_q);
    at_min_d  = (32'(value_d) == MIN_VAL);
    at_max_d  = (32'(value_d) == MAX_VAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= WIDTH'(INIT_VAL);
      changed_q <= 1'b0;
      at_min_q  <= (INIT_VAL == MIN_VAL);
      at_max_q  <= (INIT_VAL == MAX_VAL);
    end else begin
      value_q   <= value_d;
      changed_q <= changed_d;
      at_min_q  <= at_min_d;
      at_max_q  <= at_max_d;
    end
  end

  assign value_o   = value_q;
  assign changed_o = changed_q;
  assign at_min_o  = at_min_q;
  assign at_max_o  = at_max_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Self-checking bench for btn_step_ctrl with a small configuration:
// WIDTH=4, MIN=0, MAX=5, INIT=2, STEP=1, HOLD=10, REPEAT=4.
module tb_btn_step_ctrl;

  localparam int W    = 4;
  localparam int MINV = 0;
  localparam int MAXV = 5;
  localparam int INIT = 2;
  localparam int STP  = 1;
  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         up_i = 1'b0;
  logic         down_i = 1'b0;
  logic [W-1:0] value_o;
  logic         changed_o;
  logic         at_min_o;
  logic         at_max_o;

  int errors = 0;
  int checks = 0;

  btn_step_ctrl #(
    .WIDTH        (W),
    .MIN_VAL      (MINV),
    .MAX_VAL      (MAXV),
    .INIT_VAL     (INIT),
    .STEP         (STP),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_i     (up_i),
    .down_i   (down_i),
    .value_o  (value_o),
    .changed_o(changed_o),
    .at_min_o (at_min_o),
    .at_max_o (at_max_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up;
    logic dn;
    int   v;
    logic c;
    logic mn;
    logic mx;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int ev, input logic ec, input logic emn,
                       input logic emx);
    checks++;
    if (int'(value_o) != ev || changed_o !== ec || at_min_o !== emn || at_max_o !== emx) begin
      errors++;
      $display("FAIL %s: got value=%0d changed=%0b min=%0b max=%0b, want value=%0d changed=%0b min=%0b max=%0b",
               name, value_o, changed_o, at_min_o, at_max_o, ev, ec, emn, emx);
    end
  endtask

  function automatic bit is_event(int k);
    return (k == 0) || (k >= HOLD && ((k - HOLD) % REP) == 0);
  endfunction

  initial begin
    int exp_v;
    int nv;
    logic ec;
    int pulses;

    // Short presses, top saturation, a simultaneous press, back-to-back events.
    tbl[0]  = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};

    // Reset
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("reset", INIT, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      up_i   = tbl[i].up;
      down_i = tbl[i].dn;
      tick();
      check($sformatf("vec%0d", i), tbl[i].v, tbl[i].c, tbl[i].mn, tbl[i].mx);
    end

    // Climb to MAX, then hold down for 30 cycles.
    up_i = 1'b1; tick();
    up_i = 1'b0; tick();
    tick();
    check("pre_repeat", 5, 1'b0, 1'b0, 1'b1);

    exp_v  = 5;
    pulses = 0;
    down_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      ec = 1'b0;
      if (k >= 1 && is_event(k - 1)) begin
        nv = (exp_v < MINV + STP) ? MINV : exp_v - STP;
        ec = (nv != exp_v);
        exp_v = nv;
      end
      if (changed_o === 1'b1) pulses++;
      check($sformatf("repeat_k%0d", k), exp_v, ec, exp_v == MINV, exp_v == MAXV);
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL repeat_pulses: got %0d, want 5", pulses);
    end
    down_i = 1'b0;
    tick();

    // Back up to 2, then press both together and hold.
    up_i = 1'b1; tick();
    up_i = 1'b0; tick();
    up_i = 1'b1; tick();
    up_i = 1'b0; tick();
    tick();
    check("pre_simul", 2, 1'b0, 1'b0, 1'b0);
    up_i   = 1'b1;
    down_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("simul_k%0d", k), 2, 1'b0, 1'b0, 1'b0);
    end
    up_i   = 1'b0;
    down_i = 1'b0;
    tick();

    // Hold up into REPEAT, reset mid-hold, release reset with up still high.
    up_i = 1'b1;
    for (int k = 0; k < 13; k++) tick();
    check("pre_reset", 4, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset", INIT, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("held_k%0d", k), 2, 1'b0, 1'b0, 1'b0);
    end
    up_i = 1'b0; tick();
    up_i = 1'b1; tick();
    up_i = 1'b0; tick();
    check("repress", 3, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
